// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch constants, region decode and word type
package fetch_stage_pkg;
   typedef logic [31:0] word_t;

   localparam word_t      RESET_PC    = 32'h4000_0000;
   localparam word_t      NOP         = 32'h0000_0013;
   localparam logic [3:0] BIOS_REGION = 4'h4;
   localparam logic [3:0] IMEM_REGION = 4'h1;

   typedef enum logic [1:0] {
      SRC_BIOS,
      SRC_IMEM,
      SRC_ILLEGAL
   } src_e;

   function automatic src_e region_src(input logic [3:0] region);
      case (region)
         BIOS_REGION: return SRC_BIOS;
         IMEM_REGION: return SRC_IMEM;
         default:     return SRC_ILLEGAL;
      endcase
   endfunction
endpackage

// File: rtl/fetch_pc_mux.sv
// rtl/fetch_pc_mux.sv - next-PC priority mux: reset, redirect, stall, sequential
module fetch_pc_mux
   import fetch_stage_pkg::*;
(
   input  logic  rst,
   input  logic  pc_sel_ex,
   input  logic  stall,
   input  word_t reset_pc,
   input  word_t pc_q,
   input  word_t target_ex,
   output word_t next_pc
);
   // Redirect beats stall: the redirecting instruction is older than the stalled one.
   always_comb begin
      next_pc = pc_q + 32'd4;
      if (!rst)
         next_pc = reset_pc - 32'd4;
      else if (pc_sel_ex)
         next_pc = target_ex;
      else if (stall)
         next_pc = pc_q;
   end
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF/ID front end: PC register, memory select, squash, fault and count
module fetch_stage #(
   parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC,
   parameter logic [31:0] NOP      = fetch_stage_pkg::NOP,
   parameter int          BIOS_AW  = 12,
   parameter int          IMEM_AW  = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               pc_sel_ex,
   input  logic [31:0]        target_ex,
   output logic [BIOS_AW-1:0] bios_addr,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        bios_dout,
   input  logic [31:0]        imem_dout,
   output logic [31:0]        pc_id,
   output logic [31:0]        inst_id,
   output logic               valid_id,
   output logic               fetch_fault,
   output logic [31:0]        fetch_count
);
   import fetch_stage_pkg::*;

   word_t pc_q, next_pc, count_q, sel_dout;
   logic  valid_q, fault_q;
   logic  legal, aligned, ok;
   src_e  src;

   fetch_pc_mux u_pc_mux (
      .rst       (rst),
      .pc_sel_ex (pc_sel_ex),
      .stall     (stall),
      .reset_pc  (RESET_PC),
      .pc_q      (pc_q),
      .target_ex (target_ex),
      .next_pc   (next_pc)
   );

   // Synchronous-read memories: data for next_pc arrives when it becomes pc_q.
   assign bios_addr = next_pc[BIOS_AW+1:2];
   assign imem_addr = next_pc[IMEM_AW+1:2];

   always_comb begin
      src      = region_src(pc_q[31:28]);
      legal    = (src != SRC_ILLEGAL);
      aligned  = (pc_q[1:0] == 2'b00);
      sel_dout = (src == SRC_IMEM) ? imem_dout : bios_dout;
      ok       = rst & valid_q & legal & aligned & ~pc_sel_ex;
   end

   assign valid_id    = ok;
   assign inst_id     = ok ? sel_dout : NOP;
   assign pc_id       = rst ? pc_q : (RESET_PC - 32'd4);
   assign fetch_fault = fault_q;
   assign fetch_count = count_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q    <= RESET_PC - 32'd4;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         count_q <= '0;
      end else begin
         pc_q    <= next_pc;
         valid_q <= 1'b1;
         // Squashed slots never fault; the wrong path is not architecturally fetched.
         if (valid_q && !pc_sel_ex && !(legal && aligned))
            fault_q <= 1'b1;
         if (ok && !stall)
            count_q <= count_q + 32'd1;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed vectors
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        rst, stall, pc_sel_ex;
   logic [31:0] target_ex;
   logic [11:0] bios_addr;
   logic [13:0] imem_addr;
   logic [31:0] bios_dout, imem_dout;
   logic [31:0] pc_id, inst_id, fetch_count;
   logic        valid_id, fetch_fault;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;
   exp_t exp_q[$];

   localparam logic [31:0] NOP_W = 32'h0000_0013;

   fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .pc_sel_ex   (pc_sel_ex),
      .target_ex   (target_ex),
      .bios_addr   (bios_addr),
      .imem_addr   (imem_addr),
      .bios_dout   (bios_dout),
      .imem_dout   (imem_dout),
      .pc_id       (pc_id),
      .inst_id     (inst_id),
      .valid_id    (valid_id),
      .fetch_fault (fetch_fault),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] bw(input int i);
      return 32'hB105_0000 + i;
   endfunction

   function automatic logic [31:0] iw(input int i);
      return 32'h1AE0_0000 + i;
   endfunction

   // Memory contents encode their own word index.
   always @(posedge clk) begin
      bios_dout <= 32'hB105_0000 + {20'h0, bios_addr};
      imem_dout <= 32'h1AE0_0000 + {18'h0, imem_addr};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      e.pc   = pc;
      e.inst = inst;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input logic r, input logic s, input logic p, input logic [31:0] t);
      @(posedge clk);
      #1;
      rst       = r;
      stall     = s;
      pc_sel_ex = p;
      target_ex = t;
      @(negedge clk);
   endtask

   // Monitor: every delivered instruction is popped and compared.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && valid_id === 1'b1 && stall === 1'b0) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_delivery: got pc %h inst %h expected none", pc_id, inst_id);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("deliver_pc", pc_id, e.pc);
               check("deliver_inst", inst_id, e.inst);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; stall = 1'b0; pc_sel_ex = 1'b0; target_ex = '0;

      push(32'h4000_0000, bw(0)); push(32'h4000_0004, bw(1)); push(32'h4000_0008, bw(2));
      push(32'h4000_000C, bw(3)); push(32'h4000_0010, bw(4)); push(32'h4000_0014, bw(5));
      push(32'h1000_0000, iw(0));
      push(32'h4000_0000, bw(0)); push(32'h4000_0004, bw(1)); push(32'h4000_0100, bw(32'h40));
      push(32'h4000_0000, bw(0)); push(32'h4000_0004, bw(1));
      push(32'h4000_000C, bw(3)); push(32'h4000_0010, bw(4));

      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      check("rst_pc", pc_id, 32'h3FFF_FFFC);
      check("rst_valid", valid_id, 0);
      check("rst_inst", inst_id, NOP_W);
      check("rst_fault", fetch_fault, 0);
      check("rst_count", fetch_count, 0);

      cyc(1, 0, 0, 0);                                   // cycle 0: bubble
      check("c0_valid", valid_id, 0);
      check("c0_bios_addr", bios_addr, 12'h000);
      cyc(1, 0, 0, 0);                                   // 1: 0x00
      check("c1_valid", valid_id, 1);
      cyc(1, 0, 0, 0);                                   // 2: 0x04
      cyc(1, 0, 0, 0);                                   // 3: 0x08
      cyc(1, 0, 0, 0);                                   // 4: 0x0C
      check("c4_count", fetch_count, 3);
      for (int i = 0; i < 3; i++) begin                  // 5-7: stall at 0x10
         cyc(1, 1, 0, 0);
         check("stall_pc", pc_id, 32'h4000_0010);
         check("stall_inst", inst_id, bw(4));
         check("stall_bios_addr", bios_addr, 12'h004);
         check("stall_count", fetch_count, 4);
      end
      cyc(1, 0, 0, 0);                                   // 8: 0x10 delivered
      cyc(1, 0, 0, 0);                                   // 9: 0x14
      cyc(1, 1, 1, 32'h1000_0000);                       // 10: 0x18 squashed, stall+redirect
      check("sr_valid", valid_id, 0);
      check("sr_inst", inst_id, NOP_W);
      cyc(1, 0, 0, 0);                                   // 11: IMEM word 0
      check("c11_count", fetch_count, 6);
      check("c11_imem_addr", imem_addr, 14'h0001);
      cyc(1, 0, 1, 32'h2000_0000);                       // 12: redirect to illegal
      cyc(1, 0, 0, 0);                                   // 13: illegal fetch
      check("ill_valid", valid_id, 0);
      check("ill_inst", inst_id, NOP_W);
      check("ill_fault_pre", fetch_fault, 0);
      cyc(1, 0, 1, 32'h4000_0000);                       // 14: back to BIOS
      check("ill_fault", fetch_fault, 1);
      cyc(1, 0, 0, 0);                                   // 15: 0x00
      check("fault_sticky", fetch_fault, 1);
      cyc(1, 0, 0, 0);                                   // 16: 0x04
      cyc(1, 0, 1, 32'h4000_0100);                       // 17: 0x08 squashed by branch
      check("br_valid", valid_id, 0);
      check("br_inst", inst_id, NOP_W);
      check("br_count", fetch_count, 9);
      cyc(1, 0, 0, 0);                                   // 18: 0x100
      check("br_count_after", fetch_count, 9);
      cyc(1, 1, 0, 0);                                   // 19: stall at 0x104
      cyc(0, 1, 0, 0);                                   // 20: reset mid-stall
      check("mid_rst_pc", pc_id, 32'h3FFF_FFFC);
      check("mid_rst_valid", valid_id, 0);
      check("mid_rst_inst", inst_id, NOP_W);
      cyc(1, 0, 0, 0);                                   // 21: bubble
      check("post_rst_pc", pc_id, 32'h3FFF_FFFC);
      check("post_rst_valid", valid_id, 0);
      check("post_rst_fault", fetch_fault, 0);
      check("post_rst_count", fetch_count, 0);
      cyc(1, 0, 0, 0);                                   // 22: 0x00
      cyc(1, 0, 0, 0);                                   // 23: 0x04
      cyc(1, 0, 1, 32'h4000_0002);                       // 24: 0x08 squashed
      cyc(1, 0, 0, 0);                                   // 25: misaligned fetch
      check("mis_valid", valid_id, 0);
      check("mis_inst", inst_id, NOP_W);
      check("mis_fault_pre", fetch_fault, 0);
      cyc(1, 0, 1, 32'h4000_000C);                       // 26
      check("mis_fault", fetch_fault, 1);
      cyc(1, 0, 0, 0);                                   // 27: 0x0C
      cyc(1, 0, 0, 0);                                   // 28: 0x10
      check("end_count", fetch_count, 3);
      cyc(1, 1, 0, 0);
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
